// File: rtl/dcache_if.sv
// CPU, memory and data-array signals of the data-cache controller.
// The slave modport is the controller; the master modport is its environment.
interface dcache_if #(
  parameter int unsigned SET_W  = 3,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned BE_W   = DATA_W / 8;

  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_byte;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              inv;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              arr_we;
  logic [SET_W-1:0]  arr_set;
  logic              arr_way;
  logic [WORD_W-1:0] arr_word;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, inv, mem_ack, mem_rdata, arr_rdata,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output arr_we, arr_set, arr_way, arr_word, arr_be, arr_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata, inv, mem_ack, mem_rdata, arr_rdata,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  arr_we, arr_set, arr_way, arr_word, arr_be, arr_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// 2-way set-associative data-cache sequencer: hit check, LRU, 4-beat refill on
// load miss, write-through / no-write-allocate stores.
module dcache_ctrl #(
  parameter int unsigned TAG_W  = 25,
  parameter int unsigned SET_W  = 3,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  dcache_if.slave   bus
);
  localparam int unsigned NSETS  = 2 ** SET_W;
  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StRefill, StResp, StWrite} state_e;

  state_e                  state_q, state_d;
  logic [NSETS-1:0][1:0]   valid_q;
  logic [NSETS-1:0]        lru_q;
  logic [TAG_W-1:0]        tag_q [NSETS][2];
  logic                    victim_q;
  logic [WORD_W-1:0]       cnt_q;
  logic                    hit_q;
  logic                    hit_way_q;

  logic [TAG_W-1:0]  addr_tag;
  logic [SET_W-1:0]  addr_set;
  logic [WORD_W-1:0] addr_word;
  logic [1:0]        addr_byte;
  logic              hit0, hit1, hit, victim, last_beat;
  logic [BE_W-1:0]   st_be;
  logic [DATA_W-1:0] st_data;

  assign addr_tag  = bus.cpu_addr[31 -: TAG_W];
  assign addr_set  = bus.cpu_addr[2+WORD_W +: SET_W];
  assign addr_word = bus.cpu_addr[2 +: WORD_W];
  assign addr_byte = bus.cpu_addr[1:0];

  assign hit0 = valid_q[addr_set][0] && (tag_q[addr_set][0] == addr_tag);
  assign hit1 = valid_q[addr_set][1] && (tag_q[addr_set][1] == addr_tag);
  assign hit  = hit0 | hit1;

  // Fill an empty way first (way 0 preferred) before evicting the LRU way.
  assign victim = !valid_q[addr_set][0] ? 1'b0 :
                  !valid_q[addr_set][1] ? 1'b1 : lru_q[addr_set];

  assign last_beat = (cnt_q == WORD_W'(WORDS - 1));

  assign st_be   = bus.cpu_byte ? (BE_W'(1) << addr_byte) : {BE_W{1'b1}};
  assign st_data = bus.cpu_byte ? {(DATA_W/8){bus.cpu_wdata[7:0]}} : bus.cpu_wdata;

  assign bus.cpu_rdata = bus.cpu_byte ?
                         {{(DATA_W-8){1'b0}}, bus.arr_rdata[{addr_byte, 3'b000} +: 8]} :
                         bus.arr_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.inv && bus.cpu_req) begin
          if (bus.cpu_we)  state_d = StWrite;
          else if (!hit)   state_d = StRefill;
        end
      end
      StRefill: if (bus.mem_ack && last_beat) state_d = StResp;
      StResp:   state_d = StIdle;
      StWrite:  if (bus.mem_ack) state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.cpu_ready = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    bus.arr_we    = 1'b0;
    bus.arr_set   = addr_set;
    bus.arr_way   = hit1;
    bus.arr_word  = addr_word;
    bus.arr_be    = '0;
    bus.arr_wdata = '0;
    unique case (state_q)
      StIdle: begin
        bus.cpu_ready = !bus.inv && bus.cpu_req && !bus.cpu_we && hit;
      end
      StRefill: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addr_tag, addr_set, cnt_q, 2'b00};
        bus.arr_way  = victim_q;
        bus.arr_word = cnt_q;
        if (bus.mem_ack) begin
          bus.arr_we    = 1'b1;
          bus.arr_be    = {BE_W{1'b1}};
          bus.arr_wdata = bus.mem_rdata;
        end
      end
      StResp: begin
        bus.arr_way   = victim_q;
        bus.cpu_ready = 1'b1;
      end
      StWrite: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = st_data;
        bus.mem_be    = st_be;
        bus.arr_way   = hit_way_q;
        if (bus.mem_ack) begin
          bus.cpu_ready = 1'b1;
          bus.arr_we    = hit_q;
          bus.arr_be    = st_be;
          bus.arr_wdata = st_data;
        end
      end
    endcase
  end

  // Victim is invalidated at miss detection so a half-filled line never hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      lru_q     <= '0;
      victim_q  <= 1'b0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      hit_way_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.inv) begin
            valid_q <= '0;
            lru_q   <= '0;
          end else if (bus.cpu_req) begin
            if (bus.cpu_we) begin
              hit_q     <= hit;
              hit_way_q <= hit1;
            end else if (hit) begin
              lru_q[addr_set] <= ~hit1;
            end else begin
              victim_q                 <= victim;
              valid_q[addr_set][victim] <= 1'b0;
              cnt_q                    <= '0;
            end
          end
        end
        StRefill: begin
          if (bus.mem_ack) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              valid_q[addr_set][victim_q] <= 1'b1;
              lru_q[addr_set]             <= ~victim_q;
            end
          end
        end
        StWrite: begin
          if (bus.mem_ack && hit_q) lru_q[addr_set] <= ~hit_way_q;
        end
        StResp: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StRefill && bus.mem_ack && last_beat) begin
      tag_q[addr_set][victim_q] <= addr_tag;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a memory responder, data-array model and
// reference memory; expected loads and memory transactions go through queues.
module tb_dcache_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_if bus ();

  dcache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  mem_exp_t    exp_mem_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] bmem    [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] arr_mem [0:63];
  int          checks = 0;
  int          errors = 0;
  int          ack_wait = 0;
  int          wcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Data array: combinational read, byte-enabled write on the clock edge.
  assign bus.arr_rdata = arr_mem[{bus.arr_set, bus.arr_way, bus.arr_word}];
  always @(posedge clk) begin
    if (bus.arr_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.arr_be[b])
          arr_mem[{bus.arr_set, bus.arr_way, bus.arr_word}][8*b +: 8] <= bus.arr_wdata[8*b +: 8];
    end
  end

  // Memory responder: ack_wait stall cycles before each acked beat.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.mem_req) begin
      if (wcnt >= ack_wait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bmem[bus.mem_addr[11:2]];
        wcnt          = 0;
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt        = 0;
    end
  end

  always @(negedge clk) begin : mem_check
    mem_exp_t e;
    if (rst_n && bus.mem_req) begin
      if (exp_mem_q.size() == 0) begin
        check("mem_unexpected", 32'(bus.mem_req), 32'd0);
      end else begin
        e = exp_mem_q[0];
        check("mem_addr", bus.mem_addr, e.addr);
        if (bus.mem_ack) begin
          check("mem_we", 32'(bus.mem_we), 32'(e.we));
          if (e.we) begin
            check("mem_be", 32'(bus.mem_be), 32'(e.be));
            check("mem_wdata", bus.mem_wdata, e.wdata);
            for (int b = 0; b < 4; b++)
              if (bus.mem_be[b]) bmem[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
          end
          void'(exp_mem_q.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(output int cyc, output bit done);
    cyc  = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.cpu_ready) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
  endtask

  task automatic finish_req(input string tag, input int cyc, input bit done, input int exp_lat);
    if (!done) begin
      check({tag, "_timeout"}, 32'(bus.cpu_ready), 32'd1);
      exp_mem_q.delete();
    end else begin
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic byt,
                         input bit exp_hit);
    logic [31:0] w, exp;
    mem_exp_t    e;
    int          cyc;
    bit          done;
    w   = ref_mem[addr[11:2]];
    exp = byt ? {24'b0, w[8*addr[1:0] +: 8]} : w;
    exp_rd_q.push_back(exp);
    if (!exp_hit) begin
      for (int b = 0; b < 4; b++) begin
        e = '0;
        e.addr = {addr[31:4], b[1:0], 2'b00};
        exp_mem_q.push_back(e);
      end
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_byte  = byt;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = '0;
    wait_ready(cyc, done);
    exp = exp_rd_q.pop_front();
    if (done) check({tag, "_rdata"}, bus.cpu_rdata, exp);
    finish_req(tag, cyc, done, exp_hit ? 0 : 4 * (ack_wait + 1) + 1);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic byt,
                          input logic [31:0] data);
    mem_exp_t e;
    int       cyc;
    bit       done;
    e.we    = 1'b1;
    e.addr  = addr;
    e.be    = byt ? (4'b0001 << addr[1:0]) : 4'hF;
    e.wdata = byt ? {4{data[7:0]}} : data;
    for (int b = 0; b < 4; b++)
      if (e.be[b]) ref_mem[addr[11:2]][8*b +: 8] = e.wdata[8*b +: 8];
    exp_mem_q.push_back(e);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_byte  = byt;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    wait_ready(cyc, done);
    finish_req(tag, cyc, done, ack_wait + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ready"}, 32'(bus.cpu_ready), 32'd0);
    check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
    check({tag, "_arr_we"}, 32'(bus.arr_we), 32'd0);
    check({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
  endtask

  initial begin
    int acks;
    for (int i = 0; i < 1024; i++) begin
      bmem[i]    = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    for (int i = 0; i < 4; i++) begin
      bmem[16+i]    = 32'hA0 + 32'(i);
      ref_mem[16+i] = 32'hA0 + 32'(i);
    end
    for (int i = 0; i < 64; i++) arr_mem[i] = '0;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0;
    bus.cpu_addr = '0;  bus.cpu_wdata = '0; bus.inv = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_load("miss_40", 32'h40, 1'b0, 1'b0);
    do_load("hit_44", 32'h44, 1'b0, 1'b1);

    ack_wait = 3;
    do_load("stall_200", 32'h200, 1'b0, 1'b0);
    ack_wait = 0;

    // Invalidate has priority over a simultaneous request.
    bus.inv = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0;
    bus.cpu_addr = 32'h44;
    @(negedge clk);
    check("inv_no_ready", 32'(bus.cpu_ready), 32'd0);
    @(posedge clk); #1;
    bus.inv = 1'b0; bus.cpu_req = 1'b0;
    do_load("inv_miss_44", 32'h44, 1'b0, 1'b0);

    bus.inv = 1'b1;
    @(posedge clk); #1;
    bus.inv = 1'b0;
    do_load("set4_t1", 32'hC0, 1'b0, 1'b0);
    do_load("set4_t2", 32'h140, 1'b0, 1'b0);
    do_load("set4_t1_hit", 32'hC4, 1'b0, 1'b1);
    do_load("set4_t3", 32'h1C0, 1'b0, 1'b0);
    do_load("set4_t1_kept", 32'hC8, 1'b0, 1'b1);
    do_load("set4_t2_evicted", 32'h144, 1'b0, 1'b0);

    do_store("sb_hit", 32'hC2, 1'b1, 32'h0000_005A);
    do_load("lbu_after_sb", 32'hC2, 1'b1, 1'b1);
    do_load("lw_after_sb", 32'hC0, 1'b0, 1'b1);
    do_store("sw_miss", 32'h300, 1'b0, 32'h1234_5678);
    do_load("lw_after_sw_miss", 32'h300, 1'b0, 1'b0);
    do_store("sw_hit", 32'h148, 1'b0, 32'hDEAD_BEEF);
    do_load("lw_after_sw_hit", 32'h148, 1'b0, 1'b1);

    // Abort a refill with reset during its third beat.
    for (int b = 0; b < 4; b++) begin
      mem_exp_t e;
      e = '0;
      e.addr = {28'h000_001C, b[1:0], 2'b00};
      exp_mem_q.push_back(e);
    end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_byte = 1'b0; bus.cpu_addr = 32'h1C0;
    acks = 0;
    for (int i = 0; i < 50 && acks < 2; i++) begin
      @(negedge clk);
      if (bus.mem_ack) acks++;
    end
    check("abort_acks", 32'(acks), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    exp_mem_q.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_load("refill_after_reset", 32'h1C0, 1'b0, 1'b0);
    do_load("miss_after_reset", 32'hC0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
